// File: rtl/bcd_convert_seq.sv
// Purpose: sequential 16-bit binary to 4-digit BCD converter (shift-add-3) feeding the 7-segment driver.
// Latency: 17 clocks from the capture edge to the edge that raises done; next capture no earlier than one edge later.
// Backpressure: none; triggers arriving while busy are ignored (no queueing). With AUTO=1 a value that still differs retriggers from IDLE.
//
// Ports:
//   clkin    - clock, all state changes on posedge
//   reset    - synchronous, active-high reset
//   bin_in   - unsigned binary value to convert
//   start    - conversion request, sampled only in IDLE
//   busy     - 1 while a conversion is in progress
//   done     - single-cycle pulse when bcd_out updates
//   bcd_out  - four BCD digits, [15:12] thousands .. [3:0] units, held between conversions
//   overflow - 1 when bcd_out holds OVF_CODE (captured value above 9999)
module bcd_convert_seq #(
    parameter logic [15:0] OVF_CODE = 16'hEEEE,
    parameter bit          AUTO     = 1'b1
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [15:0] bin_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [15:0] last_q;
    logic [19:0] scratch_q;
    logic [3:0]  cnt_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] bcd_q;
    logic        overflow_q;

    logic [19:0] scratch_adj_d;
    logic        trigger_d;

    // Add-3 correction on every digit in parallel before the shift. A digit
    // >= 5 is at most 9 here, so +3 stays within 4 bits.
    always_comb begin
        scratch_adj_d = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign trigger_d = start || (AUTO && (bin_in != last_q));

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= 16'h0000;
            last_q     <= 16'h0000;
            scratch_q  <= 20'h00000;
            cnt_q      <= 4'd0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trigger_d) begin
                        shift_q   <= bin_in;
                        last_q    <= bin_in;
                        scratch_q <= 20'h00000;
                        cnt_q     <= 4'd0;
                        ovf_q     <= (bin_in > 16'd9999);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= {scratch_adj_d[18:0], shift_q[15]};
                    shift_q   <= {shift_q[14:0], 1'b0};
                    cnt_q     <= cnt_q + 4'd1;
                    // cnt_q==15 marks the 16th and final iteration.
                    if (cnt_q == 4'd15) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q      <= ovf_q ? OVF_CODE : scratch_q[15:0];
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: one instance with AUTO=0, one with AUTO=1.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bin0, bin1;
    logic        start0, start1;
    logic        busy0, done0, ovf0;
    logic        busy1, done1, ovf1;
    logic [15:0] bcd0, bcd1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.OVF_CODE(16'hEEEE), .AUTO(1'b0)) dut0 (
        .clkin(clk), .reset(reset), .bin_in(bin0), .start(start0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0)
    );

    bcd_convert_seq #(.OVF_CODE(16'hEEEE), .AUTO(1'b1)) dut1 (
        .clkin(clk), .reset(reset), .bin_in(bin1), .start(start1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the selected instance shows done, at most 60 edges.
    task automatic wait_done(input int sel, output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!((sel == 1) ? done1 : done0) && n < 60) begin
            if ((sel == 1) ? busy1 : busy0) busy_n++;
            tick();
            n++;
        end
    endtask

    // Full conversion on the AUTO=0 instance with latency/hold checks.
    task automatic conv0(input string tag, input logic [15:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf,
                         input logic [15:0] prev_bcd);
        int n, bn;
        bin0 = v;
        start0 = 1'b1;
        tick();                     // capture edge k
        start0 = 1'b0;
        chk({tag, "_busy_at_k"}, busy0, 1);
        repeat (8) tick();
        chk({tag, "_held_mid"}, bcd0, prev_bcd);
        wait_done(0, n, bn);
        chk({tag, "_latency"}, n + 8, 17);
        chk({tag, "_busy_cycles"}, bn + 8, 17 - 8 + 8);
        chk({tag, "_bcd"}, bcd0, exp_bcd);
        chk({tag, "_ovf"}, ovf0, exp_ovf);
        chk({tag, "_busy_clr"}, busy0, 0);
        tick();
        chk({tag, "_done_fall"}, done0, 0);
    endtask

    initial begin
        int n, bn, cnt;
        reset = 1'b1;
        bin0 = 16'd0; bin1 = 16'd0;
        start0 = 1'b0; start1 = 1'b0;
        repeat (2) tick();
        chk("rst_bcd", bcd0, 16'h0000);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_auto_busy", busy1, 0);
        reset = 1'b0;
        tick();

        conv0("c1234", 16'd1234, 16'h1234, 1'b0, 16'h0000);
        conv0("c9999", 16'd9999, 16'h9999, 1'b0, 16'h1234);
        conv0("c10000", 16'd10000, 16'hEEEE, 1'b1, 16'h9999);
        conv0("c65535", 16'd65535, 16'hEEEE, 1'b1, 16'hEEEE);
        conv0("c0", 16'd0, 16'h0000, 1'b0, 16'hEEEE);
        conv0("c0305", 16'd305, 16'h0305, 1'b0, 16'h0000);

        // Change during conversion, AUTO=0: ignored, no second conversion.
        bin0 = 16'd42; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (5) tick();
        bin0 = 16'd77; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, n, bn);
        chk("a0_latency", n + 6, 17);
        chk("a0_bcd", bcd0, 16'h0042);
        cnt = 0;
        repeat (40) begin tick(); if (done0) cnt++; end
        chk("a0_no_retrigger", cnt, 0);
        chk("a0_bcd_held", bcd0, 16'h0042);

        // Same scenario, AUTO=1: second conversion follows automatically.
        bin1 = 16'd42; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        bin1 = 16'd77; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done(1, n, bn);
        chk("a1_first_latency", n + 6, 17);
        chk("a1_first_bcd", bcd1, 16'h0042);
        tick();                     // edge k+18: retrigger capture
        chk("a1_done_fall", done1, 0);
        chk("a1_recapture_busy", busy1, 1);
        wait_done(1, n, bn);
        chk("a1_second_latency", n, 17);
        chk("a1_second_bcd", bcd1, 16'h0077);

        // Reset during the 8th SHIFT cycle aborts without a done pulse.
        bin0 = 16'd9999; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        chk("rm_busy_before", busy0, 1);
        reset = 1'b1;
        tick();
        chk("rm_busy", busy0, 0);
        chk("rm_bcd", bcd0, 16'h0000);
        chk("rm_done", done0, 0);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin tick(); if (done0) cnt++; end
        chk("rm_no_done", cnt, 0);
        conv0("c500", 16'd500, 16'h0500, 1'b0, 16'h0000);

        // AUTO=1 from reset with a constant input: exactly one conversion.
        bin1 = 16'd7;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();                     // first IDLE edge: capture
        chk("h7_busy", busy1, 1);
        wait_done(1, n, bn);
        chk("h7_latency", n, 17);
        chk("h7_bcd", bcd1, 16'h0007);
        cnt = 0;
        repeat (100) begin tick(); if (done1) cnt++; end
        chk("h7_no_more_done", cnt, 0);
        chk("h7_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
